// File: rtl/keygen_ingress_pkg.sv
// ============================================================================
// keygen_ingress_pkg
// Shared state encoding, section selectors and lane-index sizing helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package keygen_ingress_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PARAM = 3'd1,
    ST_SK    = 3'd2,
    ST_OMEGA = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic WORD_SEL_SK    = 1'b0;
  localparam logic WORD_SEL_OMEGA = 1'b1;

  // A single-lane build still needs a 1-bit lane index.
  function automatic int clog2(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_lane_unpack.sv
// ============================================================================
// axis_lane_unpack
// One-beat buffer that emits its lanes as words, one per cycle, MSW first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_lane_unpack
  import keygen_ingress_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 2
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          i_packed,
  input  logic                          i_payload,
  input  logic                          i_hold,
  input  logic                          i_load,
  input  logic [LANES*DATA_WIDTH-1:0]   i_data,
  input  logic                          i_last,
  input  logic                          i_flush,
  output logic                          o_ready,
  output logic                          o_valid,
  output logic                          o_final,
  output logic                          o_last,
  output logic [DATA_WIDTH-1:0]         o_word
);

  localparam int                c_lane_w    = clog2(LANES);
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(LANES - 1);
  localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);

  logic [LANES*DATA_WIDTH-1:0] r_data;
  logic                        r_valid;
  logic                        r_last;
  logic [c_lane_w-1:0]         r_lane;
  logic [DATA_WIDTH-1:0]       w_lanes [LANES];
  logic                        w_final;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lanes[gi] = r_data[(LANES-1-gi)*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_final = r_valid & (~i_packed | (r_lane == c_last_lane));

  // A beat carrying tlast, or a word that closes the frame, blocks the next beat
  // so it is never captured under the finishing frame's state.
  assign o_ready = i_payload & (~r_valid | (w_final & ~r_last & ~i_hold));
  assign o_valid = r_valid;
  assign o_final = w_final;
  assign o_last  = r_last;
  assign o_word  = r_valid ? w_lanes[r_lane] : '0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_lane  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_lane  <= '0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
      r_lane  <= '0;
    end else if (r_valid) begin
      if (w_final) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        r_lane  <= r_lane + c_lane_one;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/axis_keygen_ingress.sv
// ============================================================================
// axis_keygen_ingress
// AXI4-Stream ingress: header beats -> parameter writes, payload -> word stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_keygen_ingress
  import keygen_ingress_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int LANES            = 2,
  parameter int PARAM_BEATS      = 7,
  parameter int ADDR_PARAM_WIDTH = 4,
  parameter int ADDR_MAX_WIDTH   = 12
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [LANES*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  input  logic [ADDR_MAX_WIDTH-1:0]     cfg_sk_len,
  input  logic [ADDR_MAX_WIDTH-1:0]     cfg_omega_len,
  input  logic                          cfg_packed,
  output logic                          param_we,
  output logic [ADDR_PARAM_WIDTH-1:0]   param_addr,
  output logic [LANES*DATA_WIDTH-1:0]   param_wdata,
  output logic                          word_valid,
  output logic                          word_sel,
  output logic [ADDR_MAX_WIDTH-1:0]     word_addr,
  output logic [DATA_WIDTH-1:0]         word_data,
  output logic                          done,
  output logic                          err,
  output logic                          busy
);

  localparam logic [ADDR_PARAM_WIDTH-1:0] c_last_hdr = ADDR_PARAM_WIDTH'(PARAM_BEATS - 1);
  localparam logic [ADDR_PARAM_WIDTH-1:0] c_hdr_one  = ADDR_PARAM_WIDTH'(1);
  localparam logic [ADDR_MAX_WIDTH-1:0]   c_cnt_one  = ADDR_MAX_WIDTH'(1);

  state_t                        r_state, w_state_nxt;
  logic [ADDR_MAX_WIDTH-1:0]     r_cnt, w_cnt_nxt;
  logic [ADDR_PARAM_WIDTH-1:0]   r_hdr_idx;
  logic [ADDR_MAX_WIDTH-1:0]     r_sk_len, r_omega_len;
  logic                          r_packed;
  logic                          r_param_we;
  logic [ADDR_PARAM_WIDTH-1:0]   r_param_addr;
  logic [LANES*DATA_WIDTH-1:0]   r_param_wdata;
  logic                          r_done, r_err;

  logic w_hs, w_hdr_phase, w_payload, w_hdr_last;
  logic [ADDR_PARAM_WIDTH-1:0]   w_hdr_idx;
  logic [ADDR_MAX_WIDTH-1:0]     w_sk_len, w_omega_len, w_sec_len;
  logic w_sec_last, w_hold, w_emit, w_frame_end, w_early;
  logic w_hdr_done, w_hdr_err, w_done_pay, w_err_pay;
  logic u_ready, u_valid, u_final, u_last;
  logic [DATA_WIDTH-1:0]         u_word;

  assign w_hdr_phase = (r_state == ST_IDLE) | (r_state == ST_PARAM);
  assign w_payload   = (r_state == ST_SK) | (r_state == ST_OMEGA);
  assign w_hs        = s_axis_tvalid & s_axis_tready;
  assign w_hdr_idx   = (r_state == ST_IDLE) ? '0 : r_hdr_idx;
  assign w_hdr_last  = (w_hdr_idx == c_last_hdr);

  // Lengths are taken live on the first header beat, latched thereafter.
  assign w_sk_len    = (r_state == ST_IDLE) ? cfg_sk_len    : r_sk_len;
  assign w_omega_len = (r_state == ST_IDLE) ? cfg_omega_len : r_omega_len;

  assign w_sec_len   = (r_state == ST_OMEGA) ? r_omega_len : r_sk_len;
  assign w_sec_last  = (r_cnt == (w_sec_len - c_cnt_one));
  assign w_hold      = w_payload & w_sec_last &
                       ((r_state == ST_OMEGA) | (r_omega_len == '0));
  assign w_emit      = u_valid & w_payload;
  assign w_frame_end = w_emit & w_hold;
  assign w_early     = w_emit & ~w_frame_end & u_final & u_last;
  assign w_done_pay  = w_frame_end & u_last;
  assign w_err_pay   = (w_frame_end & ~u_last) | w_early;

  axis_lane_unpack #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_unpack (
    .aclk      (aclk),
    .areset    (areset),
    .i_packed  (r_packed),
    .i_payload (w_payload),
    .i_hold    (w_hold),
    .i_load    (w_hs & w_payload),
    .i_data    (s_axis_tdata),
    .i_last    (s_axis_tlast),
    .i_flush   (w_frame_end),
    .o_ready   (u_ready),
    .o_valid   (u_valid),
    .o_final   (u_final),
    .o_last    (u_last),
    .o_word    (u_word)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hdr_done  = 1'b0;
    w_hdr_err   = 1'b0;
    case (r_state)
      ST_IDLE, ST_PARAM: begin
        if (w_hs) begin
          if (!w_hdr_last) begin
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_PARAM;
            w_hdr_err   = s_axis_tlast;
          end else if ((w_sk_len == '0) && (w_omega_len == '0)) begin
            w_state_nxt = s_axis_tlast ? ST_IDLE : ST_DRAIN;
            w_hdr_done  = s_axis_tlast;
            w_hdr_err   = ~s_axis_tlast;
          end else if (s_axis_tlast) begin
            w_state_nxt = ST_IDLE;
            w_hdr_err   = 1'b1;
          end else begin
            w_state_nxt = (w_sk_len != '0) ? ST_SK : ST_OMEGA;
            w_cnt_nxt   = '0;
          end
        end
      end
      ST_SK, ST_OMEGA: begin
        if (w_frame_end) begin
          w_state_nxt = u_last ? ST_IDLE : ST_DRAIN;
        end else if (w_early) begin
          w_state_nxt = ST_IDLE;
        end else if (w_emit) begin
          if ((r_state == ST_SK) && w_sec_last) begin
            w_state_nxt = ST_OMEGA;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + c_cnt_one;
          end
        end
      end
      ST_DRAIN: begin
        if (w_hs && s_axis_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_hdr_idx     <= '0;
      r_sk_len      <= '0;
      r_omega_len   <= '0;
      r_packed      <= 1'b0;
      r_param_we    <= 1'b0;
      r_param_addr  <= '0;
      r_param_wdata <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_param_we <= w_hs & w_hdr_phase;
      r_done     <= w_hdr_done;
      if (w_hs && w_hdr_phase) begin
        r_param_addr  <= w_hdr_idx;
        r_param_wdata <= s_axis_tdata;
        r_hdr_idx     <= w_hdr_idx + c_hdr_one;
      end
      if (w_hs && (r_state == ST_IDLE)) begin
        r_sk_len    <= cfg_sk_len;
        r_omega_len <= cfg_omega_len;
        r_packed    <= cfg_packed;
        r_err       <= w_hdr_err;
      end else if (w_hdr_err || w_err_pay) begin
        r_err       <= 1'b1;
      end
    end
  end

  assign s_axis_tready = ~areset & (w_hdr_phase | (r_state == ST_DRAIN) | u_ready);
  assign param_we      = r_param_we;
  assign param_addr    = r_param_addr;
  assign param_wdata   = r_param_wdata;
  assign word_valid    = w_emit;
  assign word_sel      = (w_emit && (r_state == ST_OMEGA)) ? WORD_SEL_OMEGA : WORD_SEL_SK;
  assign word_addr     = w_emit ? r_cnt : '0;
  assign word_data     = w_emit ? u_word : '0;
  assign done          = r_done | w_done_pay;
  assign err           = r_err | w_err_pay;
  assign busy          = (r_state != ST_IDLE);

endmodule

`default_nettype wire
